// File: rtl/vec_seq_pkg.sv
// Shared types and constants for the vector operation sequencer:
// command opcodes, FSM states and the default vector geometry and watchdog limit.
package vec_seq_pkg;

    localparam int WORDS   = 16;
    localparam int NREG    = 4;
    localparam int TIMEOUT = 255;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_MATH  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LOAD_TAIL,
        ST_STORE,
        ST_MATH_WAIT,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/vector_op_sequencer.sv
// Command-driven sequencer moving 16-word vectors between data memory and the
// register file, or kicking the math unit and waiting for it under a watchdog.
module vector_op_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int WORDS   = vec_seq_pkg::WORDS,
    parameter int NREG    = vec_seq_pkg::NREG,
    parameter int TIMEOUT = vec_seq_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [2:0]        cmd_reg,
    input  logic [ADDR_W-1:0] cmd_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rf_we,
    output logic [2:0]        rf_sel,
    output logic [3:0]        rf_word,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              mu_start,
    input  logic              mu_done,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import vec_seq_pkg::*;

    localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);
    localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [2:0]        reg_q, reg_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        i_q, i_d;
    logic [7:0]        wd_q, wd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            addr_q  <= '0;
            i_q     <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            addr_q  <= addr_d;
            i_q     <= i_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        addr_d  = addr_q;
        i_d     = i_q;
        wd_d    = wd_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    reg_d  = cmd_reg;
                    addr_d = cmd_addr;
                    i_d    = '0;
                    wd_d   = '0;
                    // Bad commands are rejected up front so no strobe ever fires for them.
                    if (cmd_op == OP_RSVD || int'(cmd_reg) >= NREG) begin
                        state_d = ST_ERR;
                    end else if (cmd_op == OP_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (cmd_op == OP_STORE) begin
                        state_d = ST_STORE;
                    end else begin
                        state_d = ST_MATH_WAIT;
                    end
                end
            end
            ST_LOAD: begin
                i_d = i_q + 4'd1;
                if (i_q == LAST_WORD) state_d = ST_LOAD_TAIL;
            end
            ST_LOAD_TAIL: state_d = ST_DONE;
            ST_STORE: begin
                i_d = i_q + 4'd1;
                if (i_q == LAST_WORD) state_d = ST_DONE;
            end
            ST_MATH_WAIT: begin
                wd_d = wd_q + 8'd1;
                if (mu_done) begin
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode from registered state only, so they clear with the async reset.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        busy      = (state_q != ST_IDLE);
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        rf_we     = 1'b0;
        rf_sel    = '0;
        rf_word   = '0;
        rf_wdata  = '0;
        mu_start  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_LOAD, ST_LOAD_TAIL: begin
                // Read data lags the address by one cycle, so the write lane trails by one;
                // the counter has wrapped to 0 in the tail, which yields lane 15.
                if (state_q == ST_LOAD) mem_addr = addr_q + ADDR_W'(i_q);
                rf_sel = reg_q;
                if (state_q == ST_LOAD_TAIL || i_q != 4'd0) begin
                    rf_we    = 1'b1;
                    rf_word  = i_q - 4'd1;
                    rf_wdata = mem_rdata;
                end
            end
            ST_STORE: begin
                rf_sel    = reg_q;
                rf_word   = i_q;
                mem_addr  = addr_q + ADDR_W'(i_q);
                mem_wdata = rf_rdata;
                mem_we    = 1'b1;
            end
            ST_MATH_WAIT: mu_start = (wd_q == 8'd0);
            ST_DONE:      done     = 1'b1;
            ST_ERR:       err      = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vector_op_sequencer.sv
// Scoreboard bench for vector_op_sequencer with behavioural memory (registered read)
// and register file (combinational read); expected writes are queued per command.
module tb_vector_op_sequencer;
    import vec_seq_pkg::*;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [2:0]        cmd_reg;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              rf_we;
    logic [2:0]        rf_sel;
    logic [3:0]        rf_word;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;
    logic              mu_start;
    logic              mu_done;
    logic              busy;
    logic              done;
    logic              err;

    always #5 clk = ~clk;

    vector_op_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_reg(cmd_reg), .cmd_addr(cmd_addr),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_sel(rf_sel), .rf_word(rf_word), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
        .mu_start(mu_start), .mu_done(mu_done),
        .busy(busy), .done(done), .err(err)
    );

    // Behavioural memory and register file
    logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rf_model  [0:7][0:15];
    logic [DATA_W-1:0] mem_rdata_reg;
    logic              fill;

    function automatic logic [31:0] mem_init(input int a);
        return 32'h1000 + 32'(a) - 32'h40;
    endfunction

    function automatic logic [31:0] rf_init(input int r, input int w);
        return (r == 1) ? 32'hA0 + 32'(w) : 32'hBEEF0000 + 32'(r * 16 + w);
    endfunction

    always @(posedge clk) begin
        if (fill) begin
            for (int a = 0; a < (1 << ADDR_W); a++) mem_model[a] <= mem_init(a);
            for (int r = 0; r < 8; r++)
                for (int w = 0; w < 16; w++) rf_model[r][w] <= rf_init(r, w);
        end else begin
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
            if (rf_we)  rf_model[rf_sel][rf_word] <= rf_wdata;
        end
        mem_rdata_reg <= mem_model[mem_addr];
    end

    assign mem_rdata = mem_rdata_reg;
    assign rf_rdata  = rf_model[rf_sel][rf_word];

    // Checking and scoreboard
    typedef struct {
        bit          is_mem;
        logic [11:0] key;
        logic [31:0] data;
        int          off;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_n = 0;
    int   t0 = 0;
    int   n_rf, n_mem, n_mu, mu_off, done_off, err_off, rdy_viol;
    int   mu_delay = -1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle offset %0d)", tag, got, exp, cyc_n - t0);
        end
    endtask

    task automatic push_exp(input bit is_mem, input int key, input logic [31:0] data, input int off);
        exp_t e;
        e.is_mem = is_mem;
        e.key    = 12'(key);
        e.data   = data;
        e.off    = off;
        sb_q.push_back(e);
    endtask

    task automatic sb_cmp(input bit is_mem, input logic [11:0] key, input logic [31:0] data, input int off);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_depth", 64'(sb_q.size()), 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check_eq("wr_kind", {63'd0, is_mem}, {63'd0, e.is_mem});
        check_eq("wr_key", {52'd0, key}, {52'd0, e.key});
        check_eq("wr_data", {32'd0, data}, {32'd0, e.data});
        check_eq("wr_cyc", 64'(off), 64'(e.off));
    endtask

    // One cycle: sample DUT outputs at the falling edge, then drive the math-unit reply.
    task automatic tick();
        int off;
        @(negedge clk);
        cyc_n++;
        off = cyc_n - t0;
        if (cmd_ready && done_off < 0 && err_off < 0) rdy_viol++;
        if (rf_we)  begin n_rf++;  sb_cmp(1'b0, {5'd0, rf_sel, rf_word}, rf_wdata, off); end
        if (mem_we) begin n_mem++; sb_cmp(1'b1, {3'd0, mem_addr}, mem_wdata, off); end
        if (mu_start) begin n_mu++; mu_off = off; end
        if (done) done_off = off;
        if (err)  err_off  = off;
        mu_done = (mu_delay >= 0 && mu_off >= 0 && off == mu_off + mu_delay);
    endtask

    task automatic issue(input op_e op, input logic [2:0] rsel, input logic [ADDR_W-1:0] addr);
        cmd_op    = op;
        cmd_reg   = rsel;
        cmd_addr  = addr;
        cmd_valid = 1'b1;
        n_rf = 0; n_mem = 0; n_mu = 0;
        mu_off = -1; done_off = -1; err_off = -1;
        check_eq("ready_accept", {63'd0, cmd_ready}, 64'd1);
        t0 = cyc_n;
        tick();
        rdy_viol  = 0;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input op_e op, input logic [2:0] rsel, input logic [ADDR_W-1:0] addr, input int budget);
        int n;
        n = 0;
        issue(op, rsel, addr);
        while (done_off < 0 && err_off < 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_off < 0 && err_off < 0) check_eq("end_timeout", 64'(n), 64'(budget + 1));
        check_eq("sb_left", 64'(sb_q.size()), 64'd0);
        tick();
        check_eq("ready_after", {63'd0, cmd_ready}, 64'd1);
        $display("cmd op=%0d reg=%0d addr=%03h: done_off=%0d err_off=%0d rf_we=%0d mem_we=%0d mu_start=%0d",
                 op, rsel, addr, done_off, err_off, n_rf, n_mem, n_mu);
    endtask

    typedef struct { op_e op; logic [2:0] rsel; } bad_t;
    bad_t bad_tab [3];

    initial begin
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_reg = 3'd0; cmd_addr = '0;
        mu_done = 1'b0; fill = 1'b1;
        n_rf = 0; n_mem = 0; n_mu = 0; mu_off = -1; done_off = -1; err_off = -1; rdy_viol = 0;
        repeat (3) @(negedge clk);

        check_eq("reset_strobes", {58'd0, busy, done, err, mem_we, rf_we, mu_start}, 64'd0);
        check_eq("reset_addr", {41'd0, mem_addr, rf_sel, rf_word}, 64'd0);
        check_eq("reset_ready", {63'd0, cmd_ready}, 64'd1);
        fill  = 1'b0;
        rst_n = 1'b1;
        tick();

        // LOAD reg 2 from 0x040
        for (int k = 0; k < 16; k++) push_exp(1'b0, (2 << 4) | k, 32'h1000 + 32'(k), k + 2);
        run_cmd(OP_LOAD, 3'd2, 9'h040, 40);
        check_eq("ld_done_cyc", 64'(done_off), 64'd18);
        check_eq("ld_rf_cnt", 64'(n_rf), 64'd16);
        check_eq("ld_other", 64'(n_mem + n_mu), 64'd0);
        check_eq("ld_busy_ready", 64'(rdy_viol), 64'd0);

        // STORE reg 1 to 0x1F8, wrapping past the top of memory
        for (int k = 0; k < 16; k++) push_exp(1'b1, (32'h1F8 + k) & 32'h1FF, 32'hA0 + 32'(k), k + 1);
        run_cmd(OP_STORE, 3'd1, 9'h1F8, 40);
        check_eq("st_done_cyc", 64'(done_off), 64'd17);
        check_eq("st_mem_cnt", 64'(n_mem), 64'd16);
        check_eq("st_err", 64'(err_off), -64'sd1);

        // MATH answered five cycles after the start pulse
        mu_delay = 5;
        run_cmd(OP_MATH, 3'd0, 9'h000, 40);
        check_eq("math_mu_cnt", 64'(n_mu), 64'd1);
        check_eq("math_mu_cyc", 64'(mu_off), 64'd1);
        check_eq("math_done_cyc", 64'(done_off), 64'd7);
        check_eq("math_ready_low", 64'(rdy_viol), 64'd0);

        // MATH never answered: watchdog error
        mu_delay = -1;
        run_cmd(OP_MATH, 3'd3, 9'h000, 300);
        check_eq("wd_err_cyc", 64'(err_off), 64'd256);
        check_eq("wd_done", 64'(done_off), -64'sd1);
        check_eq("wd_mu_cnt", 64'(n_mu), 64'd1);

        // Invalid commands: reserved op, register out of range (including the boundary)
        bad_tab[0] = '{OP_RSVD, 3'd0};
        bad_tab[1] = '{OP_LOAD, 3'd5};
        bad_tab[2] = '{OP_STORE, 3'd4};
        foreach (bad_tab[b]) begin
            run_cmd(bad_tab[b].op, bad_tab[b].rsel, 9'h010, 10);
            check_eq("bad_err_cyc", 64'(err_off), 64'd1);
            check_eq("bad_strobes", 64'(n_rf + n_mem + n_mu), 64'd0);
        end

        // Reset in the middle of a LOAD
        for (int k = 0; k < 16; k++) push_exp(1'b0, (3 << 4) | k, mem_init(32'h100 + k), k + 2);
        issue(OP_LOAD, 3'd3, 9'h100);
        repeat (6) tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_strobes", {58'd0, busy, done, err, mem_we, rf_we, mu_start}, 64'd0);
        check_eq("rst_mid_addr", {41'd0, mem_addr, rf_sel, rf_word}, 64'd0);
        check_eq("rst_mid_wdata", {mem_wdata, rf_wdata}, 64'd0);
        check_eq("rst_mid_ready", {63'd0, cmd_ready}, 64'd1);
        check_eq("rst_mid_partial", 64'(n_rf), 64'd6);
        $display("reset during LOAD after %0d register writes, %0d expected writes dropped", n_rf, sb_q.size());
        sb_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("rst_rel_ready", {62'd0, cmd_ready, busy}, 64'd2);
        check_eq("rst_no_pulse", 64'(done_off), -64'sd1);

        // Normal STORE after the reset
        for (int k = 0; k < 16; k++) push_exp(1'b1, 32'h080 + k, rf_init(0, k), k + 1);
        run_cmd(OP_STORE, 3'd0, 9'h080, 40);
        check_eq("st2_done_cyc", 64'(done_off), 64'd17);
        check_eq("st2_mem_cnt", 64'(n_mem), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vector_op_sequencer.md
# vector_op_sequencer

Command-driven controller that sequences the vector datapath: register file (four 512-bit vector registers), word-addressed 32-bit data memory, and math unit. Accepts one command at a time over a valid/ready handshake. Executes LOAD (memory → vector register, 16 words), STORE (vector register → memory, 16 words) or MATH (start math unit, wait for completion). Signals completion or error with single-cycle pulses.

## Interface
Parameters:
- ADDR_W, 9, memory word-address width
- DATA_W, 32, memory/lane word width
- WORDS, 16, words per vector (512 / DATA_W)
- NREG, 4, valid vector registers (indices 0..NREG-1)
- TIMEOUT, 255, max cycles to wait for mu_done

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept (high only in IDLE)
- cmd_op  in  2  00 LOAD, 01 STORE, 10 MATH, 11 reserved
- cmd_reg  in  3  vector register index
- cmd_addr  in  ADDR_W  memory base word address
- mem_addr  out  ADDR_W  memory word address
- mem_we  out  1  memory write strobe
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle registered latency
- rf_we  out  1  register-file word write strobe
- rf_sel  out  3  register index
- rf_word  out  4  word lane within the 512-bit register
- rf_wdata  out  DATA_W  register-file write data
- rf_rdata  in  DATA_W  register-file read word at rf_sel/rf_word, combinational
- mu_start  out  1  one-cycle math-unit start pulse
- mu_done  in  1  math-unit completion (level or pulse)
- busy  out  1  high outside IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse

## Operation
- Accept on a rising edge with cmd_valid && cmd_ready. Latch op, reg and addr. Word counter i := 0.
- Invalid command: op 11, or cmd_reg ≥ NREG. Go to ERR for one cycle: err=1, no mem/rf/mu strobes, then IDLE.
- States: IDLE, LOAD, LOAD_TAIL, STORE, MATH_WAIT, DONE, ERR.
- LOAD, i = 0..15: mem_addr = (addr + i) mod 2^ADDR_W. Each cycle from the second LOAD cycle, and in LOAD_TAIL: rf_we=1, rf_word=i-1, rf_wdata=mem_rdata, rf_sel=reg. After i=15 go to LOAD_TAIL (writes word 15), then DONE.
- STORE, i = 0..15: rf_sel=reg, rf_word=i, mem_addr=(addr+i) mod 2^ADDR_W, mem_wdata=rf_rdata, mem_we=1. After i=15 go to DONE.
- MATH: mu_start=1 for exactly the first MATH_WAIT cycle. Stay in MATH_WAIT until mu_done is sampled high, then go to DONE.
- MATH timeout: a watchdog counts MATH_WAIT cycles. If it reaches TIMEOUT with no mu_done, go to ERR.
- DONE: done=1 for one cycle, then IDLE.
- Address wrap: 0x1F8 + 15 wraps to 0x007. No error is raised.
- cmd_valid while busy is ignored, because cmd_ready=0. The requester holds its command until accepted.

## Timing
- Accept edge T0.
- LOAD: mem reads in cycles T0+1..T0+16; rf writes T0+2..T0+17; done in T0+18.
- STORE: mem writes T0+1..T0+16; done T0+17.
- MATH: mu_start in T0+1. If mu_done is sampled at edge Tm, done is high in cycle Tm+1.
- Error: err high in T0+1. Timeout err occurs TIMEOUT cycles after mu_start.
- Next accept is possible on the edge after done/err (cmd_ready high that cycle).
- Reset values: state IDLE, cmd_ready=1, all other outputs 0, counters 0.
- Reset mid-operation: outputs clear asynchronously. Partial LOAD/STORE results are not rolled back, and no done/err is issued.

## Structure
- Shared package vec_seq_pkg holds:
  - op enum (OP_LOAD, OP_STORE, OP_MATH, OP_RSVD)
  - FSM state enum
  - constants WORDS=16, NREG=4, TIMEOUT=255
- Single FSM module; no sub-module needed. Word counter (4 bits) and watchdog (8 bits) live inline.

## Test plan
- LOAD reg 2 from 0x040, memory preloaded with 0x1000+k: rf_we on 16 consecutive cycles, rf_word 0..15 with data 0x1000..0x100F; done at T0+18.
- STORE reg 1 (words 0xA0+k) to 0x1F8: mem_we 16 cycles; addresses 0x1F8..0x1FF then 0x000..0x007; done at T0+17.
- MATH with mu_done returned 5 cycles after mu_start: one mu_start pulse; done exactly one cycle after mu_done; cmd_ready low throughout.
- MATH with mu_done never asserted: err pulse 255 cycles after mu_start; block returns to IDLE.
- cmd_op=11, then cmd_reg=5: err at T0+1 each time; zero mem_we/rf_we/mu_start.
- rst_n low at T0+8 of a LOAD: outputs 0 immediately; after release cmd_ready=1; a new STORE completes normally.
